// File: rtl/serial_negator.sv
// serial_negator: bit-serial two's-complement pass/negate/abs/negative-abs unit
// Ports:
//   clk    - single clock, state updates on rising edge
//   reset  - asynchronous active-high reset
//   start  - request, accepted in IDLE or FIN (ignored while busy)
//   mode   - 00 pass, 01 negate, 10 absolute value, 11 negative absolute value
//   in     - signed operand, latched when start is accepted
//   out    - signed result register, loaded on the final serial step
//   busy   - high while the serial conversion runs
//   done   - one-cycle pulse, out valid from this cycle
//   ovf    - inverted the most negative value (only with SERIAL_NEGATOR_OVF_EN)
// Optional feature macro: SERIAL_NEGATOR_OVF_EN adds the ovf port and its logic.
module serial_negator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
`ifdef SERIAL_NEGATOR_OVF_EN
   ,output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opr;
    logic [WIDTH-1:0] res;
    logic             inv;
    logic             seen;
    logic             inv_in;
    logic             rbit;
    logic             last;
    logic             accept;
    // invert decision is made once from the operand sign at latch time
    assign inv_in = mode == 2'b01 || (mode == 2'b10 && in[WIDTH-1]) || (mode == 2'b11 && !in[WIDTH-1]);
    // copy bits through the first 1, invert every bit above it
    assign rbit   = opr[0] ^ (inv & seen);
    assign last   = cnt == CW'(WIDTH - 1);
    assign accept = start && state != RUN;
`ifdef SERIAL_NEGATOR_OVF_EN
    logic ovf_p;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            opr   <= '0;
            res   <= '0;
            inv   <= 1'b0;
            seen  <= 1'b0;
            out   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_NEGATOR_OVF_EN
            ovf_p <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            state <= RUN;
            cnt   <= '0;
            opr   <= in;
            res   <= '0;
            inv   <= inv_in;
            seen  <= 1'b0;
            busy  <= 1'b1;
            done  <= 1'b0;
`ifdef SERIAL_NEGATOR_OVF_EN
            // only the most negative value maps onto itself when inverted
            ovf_p <= inv_in && in == {1'b1, {(WIDTH-1){1'b0}}};
`endif
        end else if (state == RUN) begin
            opr  <= opr >> 1;
            res  <= {rbit, res[WIDTH-1:1]};
            seen <= seen | opr[0];
            cnt  <= cnt + CW'(1);
            if (last) begin
                state <= FIN;
                busy  <= 1'b0;
                done  <= 1'b1;
                out   <= {rbit, res[WIDTH-1:1]};
`ifdef SERIAL_NEGATOR_OVF_EN
                ovf   <= ovf_p;
`endif
            end
        end else if (state == FIN) begin
            state <= IDLE;
            done  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_negator.sv
// tb_serial_negator: randomized self-checking bench for serial_negator (WIDTH=8)
module tb_serial_negator;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic [7:0] exp_out = 8'h00;
    int         nvec = 0;
    int         nerr = 0;
`ifdef SERIAL_NEGATOR_OVF_EN
    logic       ovf;
`endif

    serial_negator #(.WIDTH(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mode(mode),
        .in(din),
        .out(dout),
        .busy(busy),
        .done(done)
`ifdef SERIAL_NEGATOR_OVF_EN
       ,.ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        nvec++;
        if (obs !== expv) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [7:0] ref_out(input logic [7:0] a, input logic [1:0] m);
        int v;
        int r;
        v = int'($signed(a));
        r = m == 2'd0 ? v : m == 2'd1 ? -v : m == 2'd2 ? (v < 0 ? -v : v) : (v < 0 ? v : -v);
        return r[7:0];
    endfunction

    function automatic logic ref_ovf(input logic [7:0] a, input logic [1:0] m);
        int v;
        v = int'($signed(a));
        return v == -128 && (m == 2'd1 || m == 2'd2);
    endfunction

    // starts an operation (accepted at the next edge), checks the RUN window
    // while throwing ignored start requests at it, ends in the DONE cycle
    task automatic run_op(input logic [7:0] a, input logic [1:0] m);
        start = 1'b1;
        din   = a;
        mode  = m;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("busy_run", {7'd0, busy}, 8'd1);
            chk("done_run", {7'd0, done}, 8'd0);
            start = i == 2 ? 1'b1 : 1'($urandom_range(0, 1));
            din   = i == 2 ? 8'd9 : 8'($urandom);
            mode  = 2'($urandom);
            @(posedge clk);
        end
        #1 start = 1'b0;
        exp_out = ref_out(a, m);
        @(negedge clk);
        chk("done_fin", {7'd0, done}, 8'd1);
        chk("busy_fin", {7'd0, busy}, 8'd0);
        chk("out", dout, exp_out);
`ifdef SERIAL_NEGATOR_OVF_EN
        chk("ovf", {7'd0, ovf}, {7'd0, ref_ovf(a, m)});
`endif
    endtask

    task automatic finish_idle();
        @(posedge clk);
        @(negedge clk);
        chk("done_idle", {7'd0, done}, 8'd0);
        chk("busy_idle", {7'd0, busy}, 8'd0);
        chk("out_hold", dout, exp_out);
    endtask

    logic [7:0] dir_a [7] = '{8'd45, 8'hFD, 8'd20, 8'd20, 8'hD0, 8'h80, 8'd0};
    logic [1:0] dir_m [7] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1};

    initial begin
        #1;
        chk("rst_out", dout, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            run_op(dir_a[i], dir_m[i]);
            finish_idle();
        end
        run_op(8'd5, 2'd1);
        run_op(8'd9, 2'd1);
        finish_idle();
        for (int i = 0; i < 40; i++) begin
            run_op(8'($urandom), 2'($urandom));
            if ($urandom_range(0, 1) == 1) finish_idle();
        end
        run_op(8'd100, 2'd0);
        finish_idle();
        start = 1'b1;
        din   = 8'd45;
        mode  = 2'd1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_out", dout, 8'h00);
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_done", {7'd0, done}, 8'd0);
`ifdef SERIAL_NEGATOR_OVF_EN
        chk("abort_ovf", {7'd0, ovf}, 8'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        exp_out = 8'h00;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_nodone", {7'd0, done}, 8'd0);
            chk("abort_nobusy", {7'd0, busy}, 8'd0);
        end
        run_op(8'd45, 2'd1);
        finish_idle();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
